// File: rtl/wb8_mem32_resp.sv
// wb8_mem32_resp: Wishbone responder for the 8-bit, 24-bit-address byte bus.
// Maps a window of that bus onto a 32-bit synchronous word memory port, one byte per bus cycle.
// Optional feature: define WB8_MEM32_RDBUF_EN to add a one-word read buffer so the bridge's
// four consecutive byte reads of a word cost a single memory read. Without it every read
// goes to memory and cache_inv_i is ignored.
// Bit numbering is big-endian throughout: bit 0 is the MSB, byte lane 0 is bits [0:7].
module wb8_mem32_resp #(
    parameter int          MEM_AW   = 11,
    parameter logic [23:0] BASE_ADR = 24'h000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [0:23]       wb_adr_i,
    input  logic [0:7]        wb_dat_i,
    output logic [0:7]        wb_dat_o,
    input  logic              wb_we_i,
    input  logic [0:0]        wb_sel_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    output logic              wb_ack_o,
    output logic [0:MEM_AW-1] mem_adr_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [0:3]        mem_be_o,
    output logic [0:31]       mem_dat_o,
    input  logic [0:31]       mem_dat_i,
    input  logic              cache_inv_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        ACK     = 2'd2
    } state_e;

    // Clears the byte offset inside the window, leaving only the bits that select the window.
    localparam logic [23:0] WIN_MASK = ~((24'd4 << MEM_AW) - 24'd1);

    state_e            state_q, state_d;
    logic [0:7]        rdata_q, rdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [0:3]        mem_be_q, mem_be_d;

    logic              hit;
    logic              req;
    logic [1:0]        lane;
    logic [4:0]        lane_bit;
    logic [0:MEM_AW-1] word_adr;
    logic              buf_hit;

    assign hit      = ((wb_adr_i & WIN_MASK) == BASE_ADR);
    assign req      = wb_cyc_i & wb_stb_i & hit;
    assign lane     = wb_adr_i[22:23];
    assign lane_bit = {lane, 3'b000};
    assign word_adr = wb_adr_i[22-MEM_AW:21];

`ifdef WB8_MEM32_RDBUF_EN
    logic [0:31]       rbuf_q, rbuf_d;
    logic [0:MEM_AW-1] tag_q, tag_d;
    logic              valid_q, valid_d;

    assign buf_hit = valid_q && (tag_q == word_adr);
`else
    logic unused_cache_inv;

    assign buf_hit          = 1'b0;
    assign unused_cache_inv = cache_inv_i;
`endif

    // Next-state and registered-output decode for the IDLE/RD_WAIT/ACK sequencer.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        rdata_d  = rdata_q;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        mem_be_d = 4'b0000;
`ifdef WB8_MEM32_RDBUF_EN
        rbuf_d   = rbuf_q;
        tag_d    = tag_q;
        valid_d  = valid_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (wb_we_i) begin
                        // A write with sel=0 still completes on the bus but touches nothing.
                        mem_en_d = wb_sel_i[0];
                        mem_we_d = wb_sel_i[0];
                        mem_be_d = wb_sel_i[0] ? (4'b1000 >> lane) : 4'b0000;
`ifdef WB8_MEM32_RDBUF_EN
                        if (wb_sel_i[0] && buf_hit) begin
                            rbuf_d[lane_bit +: 8] = wb_dat_i;
                        end
`endif
                        state_d = ACK;
                    end else if (buf_hit) begin
`ifdef WB8_MEM32_RDBUF_EN
                        rdata_d = rbuf_q[lane_bit +: 8];
`endif
                        state_d = ACK;
                    end else begin
                        mem_en_d = 1'b1;
                        state_d  = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                // Memory returns the word for the held address while mem_en_o is high.
`ifdef WB8_MEM32_RDBUF_EN
                rbuf_d  = mem_dat_i;
                tag_d   = word_adr;
                valid_d = 1'b1;
`endif
                if (wb_cyc_i) begin
                    rdata_d = mem_dat_i[lane_bit +: 8];
                    state_d = ACK;
                end else begin
                    state_d = IDLE;
                end
            end
            ACK: begin
                // Master still holds the finished request here; the next byte is taken in IDLE.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef WB8_MEM32_RDBUF_EN
        // Another agent wrote memory: the buffered copy is stale, even one captured this cycle.
        if (cache_inv_i) begin
            valid_d = 1'b0;
        end
`endif
    end

    // State and bus/memory output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset_n) begin
            state_q  <= IDLE;
            rdata_q  <= '0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            mem_be_q <= '0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            mem_en_q <= mem_en_d;
            mem_we_q <= mem_we_d;
            mem_be_q <= mem_be_d;
        end
    end

`ifdef WB8_MEM32_RDBUF_EN
    // Buffer valid flag; reset discards any buffered or in-flight word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Buffered word and its tag.
    always_ff @(posedge clk) begin
        // NOTE: data and tag carry no reset; they are never used while valid_q is low.
        rbuf_q <= rbuf_d;
        tag_q  <= tag_d;
    end
`endif

    assign wb_ack_o  = (state_q == ACK) & wb_cyc_i;
    assign wb_dat_o  = rdata_q;
    assign mem_en_o  = mem_en_q;
    assign mem_we_o  = mem_we_q;
    assign mem_be_o  = mem_be_q;
    assign mem_adr_o = word_adr;
    assign mem_dat_o = {4{wb_dat_i}};

endmodule
